noc_inject: RTL and testbench

Network injection interface that sits directly upstream of the mesh's local injection port. It accepts whole messages from a core, queues them, and serializes each one into a head flit followed by 1..MAX_LEN payload flits. Flits are presented to the router under valid/ready flow control. Messages addressed to the block's own node are dropped and flagged.

---
 rtl/noc_inject.sv | 174 +++++++++++++++++
 tb/tb_noc_inject.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject.sv
// Injection interface: queues whole messages from a core and serializes each into a head flit
// plus 1..MAX_LEN payload flits for the router's local port. Self-addressed messages are dropped.
module noc_inject #(
    parameter int unsigned MESH_WIDTH = 4,
    parameter int unsigned FLIT_W     = 8,
    parameter int unsigned MAX_LEN    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SRC_X      = 0,
    parameter int unsigned SRC_Y      = 0,
    localparam int unsigned CW = $clog2(MESH_WIDTH),
    localparam int unsigned DW = FLIT_W - 2,
    localparam int unsigned LW = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CW-1:0]         req_dest_x,
    input  logic [CW-1:0]         req_dest_y,
    input  logic [LW-1:0]         req_len,
    input  logic [MAX_LEN*DW-1:0] req_data,
    output logic [FLIT_W-1:0]     out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  drop,
    output logic [15:0]           pkt_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StHead, StPayload} state_e;

    logic [CW-1:0]         mem_x    [FIFO_DEPTH];
    logic [CW-1:0]         mem_y    [FIFO_DEPTH];
    logic [LW-1:0]         mem_len  [FIFO_DEPTH];
    logic [MAX_LEN*DW-1:0] mem_data [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, accept, self_dest, push, pop;

    state_e                state_q, state_d;
    logic [LW-1:0]         idx_q, idx_d, nxt_idx;
    logic [LW-1:0]         sh_len_q, sh_len_d;
    logic [MAX_LEN*DW-1:0] sh_data_q, sh_data_d;
    logic [FLIT_W-1:0]     out_flit_q, out_flit_d, head_flit, pay_flit;
    logic                  out_valid_q, out_valid_d, drop_q, drop_d, hs;
    logic [15:0]           pkt_count_q, pkt_count_d;

    assign full      = (count_q == FIFO_DEPTH[AW:0]);
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign self_dest = (req_dest_x == SRC_X[CW-1:0]) && (req_dest_y == SRC_Y[CW-1:0]);
    assign push      = accept && !self_dest;
    assign drop_d    = accept && self_dest;
    assign hs        = out_valid_q && out_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        head_flit                      = '0;
        head_flit[FLIT_W-1 -: 2]       = 2'b01;
        head_flit[2*CW+LW-1:0]         = {mem_x[rd_ptr_q], mem_y[rd_ptr_q], mem_len[rd_ptr_q]};
        // In HEAD the next payload flit is slot 0; in PAYLOAD it is the following slot.
        nxt_idx                        = (state_q == StHead) ? '0 : idx_q + 1'b1;
        pay_flit                       = '0;
        pay_flit[FLIT_W-1 -: 2]        = (nxt_idx == sh_len_q) ? 2'b10 : 2'b00;
        pay_flit[DW-1:0]               = sh_data_q[DW*nxt_idx +: DW];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sh_len_d    = sh_len_q;
        sh_data_d   = sh_data_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        pkt_count_d = pkt_count_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop         = 1'b1;
                    out_flit_d  = head_flit;
                    out_valid_d = 1'b1;
                    state_d     = StHead;
                end
            end
            StHead: begin
                if (hs) begin
                    out_flit_d = pay_flit;
                    idx_d      = '0;
                    state_d    = StPayload;
                end
            end
            StPayload: begin
                if (hs) begin
                    if (idx_q == sh_len_q) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        if (!empty) begin
                            pop        = 1'b1;
                            out_flit_d = head_flit;
                            state_d    = StHead;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = StIdle;
                        end
                    end else begin
                        idx_d      = nxt_idx;
                        out_flit_d = pay_flit;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            sh_len_d  = mem_len[rd_ptr_q];
            sh_data_d = mem_data[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr_q]    <= req_dest_x;
            mem_y[wr_ptr_q]    <= req_dest_y;
            mem_len[wr_ptr_q]  <= req_len;
            mem_data[wr_ptr_q] <= req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            idx_q       <= '0;
            sh_len_q    <= '0;
            sh_data_q   <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            sh_len_q    <= sh_len_d;
            sh_data_q   <= sh_data_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;
    assign drop      = drop_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_inject.sv
// Scoreboard bench for noc_inject: stimulus pushes expected flits, a negedge monitor pops and
// compares them on every out_valid/out_ready handshake.
module tb_noc_inject;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest_x, req_dest_y, req_len;
    logic [23:0] req_data;
    logic [7:0]  out_flit;
    logic        out_valid, out_ready, drop;
    logic [15:0] pkt_count;

    noc_inject dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y),
        .req_len   (req_len),
        .req_data  (req_data),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int hs_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on handshake, and hold-stable check after a stalled cycle.
    logic       stalled = 1'b0;
    logic [7:0] stall_flit = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (stalled) check("stall_hold", {23'd0, out_valid, out_flit}, {23'd0, 1'b1, stall_flit});
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flit: got unexpected %0h, expected none", out_flit);
                end else begin
                    check("flit", {24'd0, out_flit}, {24'd0, exp_q.pop_front()});
                end
            end else if (out_valid) begin
                stalled    = 1'b1;
                stall_flit = out_flit;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_exp(input logic [1:0] x, input logic [1:0] y, input logic [1:0] len,
                            input logic [23:0] data);
        exp_q.push_back({2'b01, x, y, len});
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back({(i == int'(len)) ? 2'b10 : 2'b00, data[i*6 +: 6]});
        end
    endtask

    task automatic send(input logic [1:0] x, input logic [1:0] y, input logic [1:0] len,
                        input logic [23:0] data);
        int n;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_dest_x = x;
        req_dest_y = y;
        req_len    = len;
        req_data   = data;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (n == 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=0, expected 1");
        end else if (!(x == 2'd0 && y == 2'd0)) begin
            push_exp(x, y, len, data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check({name, "_drain"}, (n < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int hs_start;
    int vcnt;
    int n;
    logic [1:0] pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_dest_x = '0;
        req_dest_y = '0;
        req_len    = '0;
        req_data   = '0;
        out_ready  = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_flit", {24'd0, out_flit}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single message: dest (2,1), len 1 -> 65, 15, AA.
        send(2'd2, 2'd1, 2'd1, {6'h00, 6'h00, 6'h2A, 6'h15});
        @(negedge clk);
        check("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_head_valid", {31'd0, out_valid}, 32'd1);
        check("lat_head_flit", {24'd0, out_flit}, 32'h65);
        drain("single");
        check("single_pkt_count", {16'd0, pkt_count}, 32'd1);

        // Backpressure: len 3 with out_ready pattern 1,0,0,1...
        hs_start = hs_total;
        send(2'd1, 2'd3, 2'd3, {6'h3F, 6'h03, 6'h02, 6'h01});
        for (n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            out_ready = pat[n % 4][0];
            if (exp_q.size() == 0 && !out_valid) break;
        end
        out_ready = 1'b1;
        drain("bp");
        check("bp_flits", hs_total - hs_start, 32'd5);
        check("bp_pkt_count", {16'd0, pkt_count}, 32'd2);

        // Queue full: A parks in the shadow stalled on its head, B..E fill the FIFO.
        out_ready = 1'b0;
        send(2'd3, 2'd3, 2'd0, {18'd0, 6'h07});
        send(2'd1, 2'd0, 2'd1, {12'd0, 6'h11, 6'h22});
        send(2'd2, 2'd2, 2'd2, {6'd0, 6'h33, 6'h0C, 6'h21});
        send(2'd3, 2'd1, 2'd3, {6'h01, 6'h3E, 6'h15, 6'h2A});
        send(2'd0, 2'd1, 2'd0, {18'd0, 6'h19});
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_dest_x = 2'd1;
        req_dest_y = 2'd1;
        @(negedge clk);
        check("full_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
            if (k < 3) check("full_ready_seq", {31'd0, req_ready}, (k >= 2) ? 32'd1 : 32'd0);
        end
        check("full_no_bubble", vcnt, 32'd16);
        @(negedge clk);
        check("full_end_idle", {31'd0, out_valid}, 32'd0);
        drain("full");
        check("full_pkt_count", {16'd0, pkt_count}, 32'd7);

        // Self-addressed drop, then a normal message right after.
        send(2'd0, 2'd0, 2'd1, {12'd0, 6'h3C, 6'h0F});
        @(negedge clk);
        check("drop_pulse", {31'd0, drop}, 32'd1);
        @(negedge clk);
        check("drop_one_cycle", {31'd0, drop}, 32'd0);
        check("drop_no_flit", {31'd0, out_valid}, 32'd0);
        check("drop_pkt_count", {16'd0, pkt_count}, 32'd7);
        send(2'd2, 2'd3, 2'd2, {6'd0, 6'h2B, 6'h1D, 6'h04});
        drain("after_drop");
        check("after_drop_pkt_count", {16'd0, pkt_count}, 32'd8);

        // Reset right after the head handshake of a len 3 message.
        out_ready = 1'b0;
        send(2'd1, 2'd2, 2'd3, {6'h05, 6'h06, 6'h07, 6'h08});
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        send(2'd3, 2'd2, 2'd0, {18'd0, 6'h2C});
        drain("post_rst");
        check("post_rst_pkt_count", {16'd0, pkt_count}, 32'd1);

        // Counter wrap via preload.
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.pkt_count_q;
        check("wrap_preload", {16'd0, pkt_count}, 32'hFFFF);
        send(2'd1, 2'd1, 2'd0, {18'd0, 6'h2E});
        drain("wrap");
        check("wrap_pkt_count", {16'd0, pkt_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
